// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - shared TAP state encodings and output vector type
package tap_pkg;

  localparam int TAP_STATE_W = 4;

  typedef enum logic [TAP_STATE_W-1:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  localparam tap_state_t TAP_RESET_STATE = TLR;

  typedef struct packed {
    logic tl_reset;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic ir_clk_en;
    logic dr_clk_en;
    logic ir_select;
    logic tdo_en;
  } tap_out_t;

  // Output vector of TLR: everything low, including the active-low tl_reset.
  localparam tap_out_t TAP_OUT_RESET = '0;

endpackage

// File: rtl/tap_controller_if.sv
// rtl/tap_controller_if.sv - TMS input and strobe/enable outputs of the TAP controller
interface tap_controller_if;

  logic tms;
  logic tl_reset;
  logic captureIR;
  logic shiftIR;
  logic updateIR;
  logic captureDR;
  logic shiftDR;
  logic updateDR;
  logic ir_clk_en;
  logic dr_clk_en;
  logic ir_select;
  logic tdo_en;

  modport master (
    input  tms,
    output tl_reset, captureIR, shiftIR, updateIR,
    output captureDR, shiftDR, updateDR,
    output ir_clk_en, dr_clk_en, ir_select, tdo_en
  );

  modport slave (
    output tms,
    input  tl_reset, captureIR, shiftIR, updateIR,
    input  captureDR, shiftDR, updateDR,
    input  ir_clk_en, dr_clk_en, ir_select, tdo_en
  );

endinterface

// File: rtl/tap_output_decode.sv
// rtl/tap_output_decode.sv - combinational map from TAP state to its Moore outputs
module tap_output_decode
  import tap_pkg::*;
(
  input  tap_state_t state,
  output tap_out_t   outs
);

  always_comb begin
    outs          = '0;
    outs.tl_reset = (state != TLR);
    case (state)
      CAP_IR:  outs.capture_ir = 1'b1;
      SH_IR:   outs.shift_ir   = 1'b1;
      UPD_IR:  outs.update_ir  = 1'b1;
      CAP_DR:  outs.capture_dr = 1'b1;
      SH_DR:   outs.shift_dr   = 1'b1;
      UPD_DR:  outs.update_dr  = 1'b1;
      default: ;
    endcase
    // IR column only; TLR and RTI route TDO from the DR side.
    outs.ir_select = state inside {SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR};
    outs.ir_clk_en = outs.capture_ir | outs.shift_ir;
    outs.dr_clk_en = outs.capture_dr | outs.shift_dr;
    outs.tdo_en    = outs.shift_ir | outs.shift_dr;
  end

endmodule

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - IEEE 1149.1 TAP state machine; TAP_STATE_OUT_EN exposes tap_state
module tap_controller
  import tap_pkg::*;
(
  input  logic                   tck,
  input  logic                   trst,
  tap_controller_if.master       bus
`ifdef TAP_STATE_OUT_EN
  ,
  output logic [TAP_STATE_W-1:0] tap_state
`endif
);

  tap_state_t state;
  tap_state_t next_state;
  tap_out_t   next_outs;
  tap_out_t   outs;

  always_comb begin
    next_state = state;
    case (state)
      TLR:      next_state = bus.tms ? TLR      : RTI;
      RTI:      next_state = bus.tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = bus.tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = bus.tms ? EX1_DR   : SH_DR;
      SH_DR:    next_state = bus.tms ? EX1_DR   : SH_DR;
      EX1_DR:   next_state = bus.tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = bus.tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   next_state = bus.tms ? UPD_DR   : SH_DR;
      UPD_DR:   next_state = bus.tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = bus.tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = bus.tms ? EX1_IR   : SH_IR;
      SH_IR:    next_state = bus.tms ? EX1_IR   : SH_IR;
      EX1_IR:   next_state = bus.tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = bus.tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   next_state = bus.tms ? UPD_IR   : SH_IR;
      UPD_IR:   next_state = bus.tms ? SEL_DR   : RTI;
      default:  next_state = TAP_RESET_STATE;
    endcase
  end

  // Decoding the next state lets the output flops switch on the same edge as the state.
  tap_output_decode u_decode (
    .state (next_state),
    .outs  (next_outs)
  );

  always_ff @(posedge tck) begin
    if (!trst) begin
      state <= TAP_RESET_STATE;
      outs  <= TAP_OUT_RESET;
    end else begin
      state <= next_state;
      outs  <= next_outs;
    end
  end

  assign bus.tl_reset  = outs.tl_reset;
  assign bus.captureIR = outs.capture_ir;
  assign bus.shiftIR   = outs.shift_ir;
  assign bus.updateIR  = outs.update_ir;
  assign bus.captureDR = outs.capture_dr;
  assign bus.shiftDR   = outs.shift_dr;
  assign bus.updateDR  = outs.update_dr;
  assign bus.ir_clk_en = outs.ir_clk_en;
  assign bus.dr_clk_en = outs.dr_clk_en;
  assign bus.ir_select = outs.ir_select;
  assign bus.tdo_en    = outs.tdo_en;

`ifdef TAP_STATE_OUT_EN
  assign tap_state = state;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// tb/tb_tap_controller.sv - randomized self-checking bench for tap_controller against a table model
module tb_tap_controller;

  localparam int S_TLR = 15, S_RTI = 12, S_SDR = 7, S_CDR = 6, S_SHDR = 2, S_E1DR = 1;
  localparam int S_PDR = 3, S_E2DR = 0, S_UDR = 5, S_SIR = 4, S_CIR = 14, S_SHIR = 10;
  localparam int S_E1IR = 9, S_PIR = 11, S_E2IR = 8, S_UIR = 13;

  logic tck = 1'b0;
  logic trst = 1'b0;
  always #5 tck = ~tck;

  tap_controller_if bus ();
`ifdef TAP_STATE_OUT_EN
  logic [3:0] tap_state;
`endif

  tap_controller dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus)
`ifdef TAP_STATE_OUT_EN
    ,
    .tap_state (tap_state)
`endif
  );

  // {tl_reset, capIR, shIR, updIR, capDR, shDR, updDR, ir_clk_en, dr_clk_en, ir_select, tdo_en}
  wire [10:0] obs = {bus.tl_reset, bus.captureIR, bus.shiftIR, bus.updateIR,
                     bus.captureDR, bus.shiftDR, bus.updateDR,
                     bus.ir_clk_en, bus.dr_clk_en, bus.ir_select, bus.tdo_en};

  int vectors = 0;
  int miscompares = 0;
  int nxt0[16];
  int nxt1[16];
  int m_state = S_TLR;

  task automatic set_edge(input int s, input int on0, input int on1);
    nxt0[s] = on0;
    nxt1[s] = on1;
  endtask

  task automatic init_model();
    set_edge(S_TLR,  S_RTI,  S_TLR);
    set_edge(S_RTI,  S_RTI,  S_SDR);
    set_edge(S_SDR,  S_CDR,  S_SIR);
    set_edge(S_SIR,  S_CIR,  S_TLR);
    set_edge(S_CDR,  S_SHDR, S_E1DR);  set_edge(S_CIR,  S_SHIR, S_E1IR);
    set_edge(S_SHDR, S_SHDR, S_E1DR);  set_edge(S_SHIR, S_SHIR, S_E1IR);
    set_edge(S_E1DR, S_PDR,  S_UDR);   set_edge(S_E1IR, S_PIR,  S_UIR);
    set_edge(S_PDR,  S_PDR,  S_E2DR);  set_edge(S_PIR,  S_PIR,  S_E2IR);
    set_edge(S_E2DR, S_SHDR, S_UDR);   set_edge(S_E2IR, S_SHIR, S_UIR);
    set_edge(S_UDR,  S_RTI,  S_SDR);   set_edge(S_UIR,  S_RTI,  S_SDR);
  endtask

  function automatic logic [10:0] exp_vec(input int s);
    logic cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, ir_col;
    cap_ir = (s == S_CIR);  sh_ir = (s == S_SHIR);  upd_ir = (s == S_UIR);
    cap_dr = (s == S_CDR);  sh_dr = (s == S_SHDR);  upd_dr = (s == S_UDR);
    ir_col = s inside {S_SIR, S_CIR, S_SHIR, S_E1IR, S_PIR, S_E2IR, S_UIR};
    return {s != S_TLR, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr,
            cap_ir | sh_ir, cap_dr | sh_dr, ir_col, sh_ir | sh_dr};
  endfunction

  // One tck edge with the given tms/trst; model advances alongside, outputs sampled 1ns later.
  task automatic step(input logic t, input logic r);
    bus.tms = t;
    trst    = r;
    @(posedge tck);
    m_state = !r ? S_TLR : (t ? nxt1[m_state] : nxt0[m_state]);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    vectors++;
    if (obs !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required %b", obs, 11'b0);
    end
`ifdef TAP_STATE_OUT_EN
    vectors++;
    if (tap_state !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_state: got %h required F", tap_state);
    end
`endif
    step(1'b0, 1'b1);
    vectors++;
    if (bus.tl_reset !== 1'b1 || obs !== exp_vec(S_RTI)) begin
      miscompares++;
      $display("FAIL release_to_rti: got %b required %b", obs, exp_vec(S_RTI));
    end
  endtask

  task automatic test_ir_scan();
    logic [3:0] to_sh = 4'b0011;
    logic [5:0] to_rti = 6'b011000;
    int cap_cnt = 0, en_cnt = 0, upd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(to_sh[i], 1'b1);
      cap_cnt += int'(bus.captureIR);
      en_cnt  += int'(bus.ir_clk_en);
    end
    vectors++;
    if (cap_cnt != 1 || en_cnt != 2 || bus.tdo_en !== 1'b1 || obs !== exp_vec(S_SHIR)) begin
      miscompares++;
      $display("FAIL ir_capture: cap=%0d en=%0d out=%b required cap=1 en=2 out=%b",
               cap_cnt, en_cnt, obs, exp_vec(S_SHIR));
    end
    for (int i = 0; i < 6; i++) begin
      step(to_rti[i], 1'b1);
      upd_cnt += int'(bus.updateIR);
      vectors++;
      if (obs !== exp_vec(m_state)) begin
        miscompares++;
        $display("FAIL ir_shift_update step %0d: got %b required %b", i, obs, exp_vec(m_state));
      end
    end
    vectors++;
    if (upd_cnt != 1 || bus.ir_select !== 1'b0 || m_state != S_RTI) begin
      miscompares++;
      $display("FAIL ir_update_count: upd=%0d ir_select=%b required upd=1 ir_select=0",
               upd_cnt, bus.ir_select);
    end
  endtask

  task automatic test_five_ones_all_states();
    for (int s = 0; s < 16; s++) begin
      int guard = 0;
      step(1'b1, 1'b0);
      while (m_state != s && guard < 300) begin
        step(1'($urandom_range(0, 1)), 1'b1);
        guard++;
      end
      vectors++;
      if (m_state != s || obs !== exp_vec(s)) begin
        miscompares++;
        $display("FAIL walk_to_state %0d: got %b required %b (steps %0d)", s, obs, exp_vec(s), guard);
      end
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
      vectors++;
      if (obs !== 11'b0) begin
        miscompares++;
        $display("FAIL five_ones_from %0d: got %b required %b", s, obs, 11'b0);
      end
`ifdef TAP_STATE_OUT_EN
      vectors++;
      if (tap_state !== 4'hF) begin
        miscompares++;
        $display("FAIL five_ones_state from %0d: got %h required F", s, tap_state);
      end
`endif
    end
  endtask

  task automatic test_pause_dr();
    logic [4:0] to_pause = 5'b01010;
    int upd_cnt = 0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(to_pause[i], 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      upd_cnt += int'(bus.updateDR);
      vectors++;
      if (obs !== exp_vec(S_PDR)) begin
        miscompares++;
        $display("FAIL pause_dr_hold %0d: got %b required %b", i, obs, exp_vec(S_PDR));
      end
    end
    step(1'b1, 1'b1);
    upd_cnt += int'(bus.updateDR);
    step(1'b0, 1'b1);
    upd_cnt += int'(bus.updateDR);
    vectors++;
    if (bus.shiftDR !== 1'b1 || upd_cnt != 0 || obs !== exp_vec(S_SHDR)) begin
      miscompares++;
      $display("FAIL pause_dr_resume: got %b upd=%0d required %b upd=0", obs, upd_cnt, exp_vec(S_SHDR));
    end
  endtask

  task automatic test_trst_mid_scan();
    logic [4:0] to_shir = 5'b00110;
    int upd_cnt = 0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(to_shir[i], 1'b1);
    for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
      step(1'b0, 1'b1);
      upd_cnt += int'(bus.updateIR);
    end
    vectors++;
    if (obs !== exp_vec(S_SHIR)) begin
      miscompares++;
      $display("FAIL reach_shift_ir: got %b required %b", obs, exp_vec(S_SHIR));
    end
    step(1'($urandom_range(0, 1)), 1'b0);
    upd_cnt += int'(bus.updateIR);
    vectors++;
    if (obs !== 11'b0 || upd_cnt != 0) begin
      miscompares++;
      $display("FAIL trst_abort: got %b upd=%0d required %b upd=0", obs, upd_cnt, 11'b0);
    end
  endtask

  task automatic test_random();
    int last_upd = -100;
    step(1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 63) != 0));
      vectors++;
      if (obs !== exp_vec(m_state)) begin
        miscompares++;
        $display("FAIL random step %0d: got %b required %b (model state %0d)", i, obs, exp_vec(m_state), m_state);
      end
`ifdef TAP_STATE_OUT_EN
      vectors++;
      if (tap_state !== 4'(m_state)) begin
        miscompares++;
        $display("FAIL random_state step %0d: got %h required %h", i, tap_state, 4'(m_state));
      end
`endif
      if (bus.updateIR || bus.updateDR) begin
        vectors++;
        if (i - last_upd < 4) begin
          miscompares++;
          $display("FAIL update_spacing step %0d: gap %0d required >= 4", i, i - last_upd);
        end
        last_upd = i;
      end
    end
  endtask

  initial begin
    bus.tms = 1'b0;
    init_model();
    test_reset();
    test_ir_scan();
    test_five_ones_all_states();
    test_pause_dr();
    test_trst_mid_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
